led_pattern_engine: RTL and testbench

Parametrised successor to the fixed 8-bit rotating LED driver: drives a WIDTH-bit LED bank with one of four runtime-selectable patterns, advanced by an internal prescaler. Adds pause, single-step and a per-advance tick output. Sits directly on the board LED pins and is also usable as a slow visual heartbeat for other blocks.

---
 rtl/led_pattern_engine_pkg.sv | 35 +++
 rtl/led_pattern_engine_prescaler.sv | 53 +++++
 rtl/led_pattern_engine.sv | 119 +++++++++++
 tb/tb_led_pattern_engine.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pattern_engine_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Package     : led_pkg
//  Description : Shared types and helpers for the LED pattern engine:
//                pattern mode encoding, bounce direction and the seed value
//                loaded into the LED register when a mode is entered.
//  Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

    typedef enum logic [1:0] {
        ROT_L  = 2'd0,
        ROT_R  = 2'd1,
        BOUNCE = 2'd2,
        FILL   = 2'd3
    } mode_e;

    typedef enum logic [0:0] {
        DN = 1'b0,
        UP = 1'b1
    } dir_e;

    // Seed pattern for a mode, returned 32 bits wide; the caller truncates to
    // its LED width. Rotations and bounce start from the MSB one-hot, fill
    // starts empty.
    function automatic logic [31:0] seed(input mode_e m, input int unsigned w);
        if (m == FILL) begin
            return 32'd0;
        end
        return 32'(1) << (w - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_pattern_engine_prescaler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : led_prescaler
//  Description : Free-running terminal counter that requests one pattern
//                advance every LIMIT+1 enabled cycles. Holds its count while
//                disabled so a paused period resumes where it stopped.
//  Ports       : clk_in    - system clock
//                resetn_in - asynchronous active-low reset
//                enable_in - count when high, hold when low
//                clear_in  - synchronous return to zero (wins over counting)
//                adv_out   - high in the cycle the count sits at LIMIT
//  Revision    : 1.0 - initial release
// ============================================================================
module led_prescaler #(
    parameter int LIMIT = 12_500_000,
    parameter int CTR_W = 32
) (
    input  logic clk_in,
    input  logic resetn_in,
    input  logic enable_in,
    input  logic clear_in,
    output logic adv_out
);

    localparam logic [CTR_W-1:0] C_LIMIT = CTR_W'(LIMIT);

    logic [CTR_W-1:0] ctr_q;
    logic [CTR_W-1:0] ctr_d;
    logic             w_at_limit;

    assign w_at_limit = (ctr_q == C_LIMIT);
    assign adv_out    = enable_in && w_at_limit;

    always_comb begin
        ctr_d = ctr_q;
        if (clear_in) begin
            ctr_d = '0;
        end else if (enable_in) begin
            ctr_d = w_at_limit ? '0 : ctr_q + CTR_W'(1);
        end
    end

    always_ff @(posedge clk_in or negedge resetn_in) begin
        if (!resetn_in) begin
            ctr_q <= '0;
        end else begin
            ctr_q <= ctr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/led_pattern_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : led_pattern_engine
//  Description : Drives a WIDTH-bit LED bank with one of four runtime
//                selectable patterns (rotate left, rotate right, bounce,
//                fill), advanced by an internal prescaler or by single steps
//                while paused.
//  Ports       : clk_in    - system clock
//                resetn_in - asynchronous active-low reset
//                mode_in   - pattern select (ROT_L, ROT_R, BOUNCE, FILL)
//                enable_in - 1 = free-running, 0 = paused
//                step_in   - one advance per cycle held high while paused
//                leds      - registered LED drive
//                tick_out  - one-cycle pulse with each newly advanced value
//  Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_engine
    import led_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LIMIT = 12_500_000,
    parameter int CTR_W = 32
) (
    input  logic             clk_in,
    input  logic             resetn_in,
    input  logic [1:0]       mode_in,
    input  logic             enable_in,
    input  logic             step_in,
    output logic [WIDTH-1:0] leds,
    output logic             tick_out
);

    localparam logic [WIDTH-1:0] C_MSB_HOT = WIDTH'(1) << (WIDTH - 1);

    mode_e            mode_q, mode_d;
    dir_e             dir_q,  dir_d;
    logic [WIDTH-1:0] leds_q, leds_d;
    logic             tick_q, tick_d;

    mode_e            w_mode_in;
    logic             w_mode_change;
    logic             w_presc_adv;
    logic             w_adv;

    assign w_mode_in     = mode_e'(mode_in);
    assign w_mode_change = (w_mode_in != mode_q);
    // Steps only count while paused; when running they are ignored.
    assign w_adv         = w_presc_adv || (!enable_in && step_in);

    led_prescaler #(
        .LIMIT (LIMIT),
        .CTR_W (CTR_W)
    ) u_prescaler (
        .clk_in    (clk_in),
        .resetn_in (resetn_in),
        .enable_in (enable_in),
        .clear_in  (w_mode_change),
        .adv_out   (w_presc_adv)
    );

    always_comb begin
        mode_d = mode_q;
        dir_d  = dir_q;
        leds_d = leds_q;
        tick_d = 1'b0;
        if (w_mode_change) begin
            // Mode switch restarts the pattern and drops any coincident advance.
            mode_d = w_mode_in;
            dir_d  = DN;
            leds_d = WIDTH'(seed(w_mode_in, WIDTH));
        end else if (w_adv) begin
            tick_d = 1'b1;
            case (mode_q)
                ROT_L:   leds_d = {leds_q[WIDTH-2:0], leds_q[WIDTH-1]};
                ROT_R:   leds_d = {leds_q[0], leds_q[WIDTH-1:1]};
                BOUNCE: begin
                    // Turn around at each end so endpoints show only once.
                    if (dir_q == DN) begin
                        if (leds_q[0]) begin
                            leds_d = leds_q << 1;
                            dir_d  = UP;
                        end else begin
                            leds_d = leds_q >> 1;
                        end
                    end else begin
                        if (leds_q[WIDTH-1]) begin
                            leds_d = leds_q >> 1;
                            dir_d  = DN;
                        end else begin
                            leds_d = leds_q << 1;
                        end
                    end
                end
                FILL:    leds_d = (&leds_q) ? '0 : {leds_q[WIDTH-2:0], 1'b1};
                default: leds_d = leds_q;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge resetn_in) begin
        if (!resetn_in) begin
            mode_q <= ROT_L;
            dir_q  <= DN;
            leds_q <= C_MSB_HOT;
            tick_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            dir_q  <= dir_d;
            leds_q <= leds_d;
            tick_q <= tick_d;
        end
    end

    assign leds     = leds_q;
    assign tick_out = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_led_pattern_engine
//  Description : Directed bench for led_pattern_engine. Three instances share
//                stimulus: A (WIDTH=8, LIMIT=3), B (WIDTH=4, LIMIT=0) and
//                C (WIDTH=8, LIMIT=5). Outputs are sampled on falling edges.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pattern_engine;

    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic [1:0] mode = 2'd0;
    logic       en = 1'b1;
    logic       step = 1'b0;

    logic [7:0] leds_a, leds_c;
    logic [3:0] leds_b;
    logic       tick_a, tick_b, tick_c;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    led_pattern_engine #(.WIDTH(8), .LIMIT(3), .CTR_W(32)) dut_a (
        .clk_in(clk), .resetn_in(rstn), .mode_in(mode), .enable_in(en),
        .step_in(step), .leds(leds_a), .tick_out(tick_a));

    led_pattern_engine #(.WIDTH(4), .LIMIT(0), .CTR_W(8)) dut_b (
        .clk_in(clk), .resetn_in(rstn), .mode_in(mode), .enable_in(en),
        .step_in(step), .leds(leds_b), .tick_out(tick_b));

    led_pattern_engine #(.WIDTH(8), .LIMIT(5), .CTR_W(16)) dut_c (
        .clk_in(clk), .resetn_in(rstn), .mode_in(mode), .enable_in(en),
        .step_in(step), .leds(leds_c), .tick_out(tick_c));

    // Reset asserted for one full cycle; returns on a falling edge with
    // reset released, so the next posedge is cycle 1.
    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        mode = 2'd0; en = 1'b1; step = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        #2;
        checks++;
        if (leds_a !== 8'h80 || tick_a !== 1'b0) begin
            failures++;
            $display("FAIL reset_a leds=%h tick=%b exp leds=80 tick=0", leds_a, tick_a);
        end
        checks++;
        if (leds_b !== 4'b1000 || tick_b !== 1'b0) begin
            failures++;
            $display("FAIL reset_b leds=%b tick=%b exp leds=1000 tick=0", leds_b, tick_b);
        end
        checks++;
        if (leds_c !== 8'h80) begin
            failures++;
            $display("FAIL reset_c leds=%h exp 80", leds_c);
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_rot_l();
        logic [7:0] exp_l [9] = '{8'h80, 8'h80, 8'h80, 8'h01, 8'h01, 8'h01, 8'h01, 8'h02, 8'h02};
        logic       exp_t [9] = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
        mode = 2'd0; en = 1'b1; step = 1'b0;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            checks++;
            if (leds_a !== exp_l[i] || tick_a !== exp_t[i]) begin
                failures++;
                $display("FAIL rot_l cyc=%0d leds=%h tick=%b exp leds=%h tick=%b",
                         i + 1, leds_a, tick_a, exp_l[i], exp_t[i]);
            end
        end
    endtask

    task automatic test_bounce();
        logic [3:0] exp_l [9] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010,
                                  4'b0100, 4'b1000, 4'b0100, 4'b0010};
        mode = 2'd2; en = 1'b1; step = 1'b0;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            checks++;
            // Cycle 1 is the mode-change edge: no tick; every later edge advances.
            if (leds_b !== exp_l[i] || tick_b !== (i != 0)) begin
                failures++;
                $display("FAIL bounce cyc=%0d leds=%b tick=%b exp leds=%b tick=%b",
                         i + 1, leds_b, tick_b, exp_l[i], (i != 0));
            end
        end
    endtask

    task automatic test_fill();
        logic [3:0] exp_l [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                  4'b0000, 4'b0001, 4'b0011};
        mode = 2'd3; en = 1'b1; step = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (leds_b !== exp_l[i] || tick_b !== (i != 0)) begin
                failures++;
                $display("FAIL fill cyc=%0d leds=%b tick=%b exp leds=%b tick=%b",
                         i + 1, leds_b, tick_b, exp_l[i], (i != 0));
            end
        end
    endtask

    task automatic test_step_pause();
        logic [7:0] exp_s [3] = '{8'h40, 8'h20, 8'h10};
        int n;
        mode = 2'd1; en = 1'b0; step = 1'b0;
        do_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (leds_c !== 8'h80 || tick_c !== 1'b0) begin
            failures++;
            $display("FAIL paused_hold leds=%h tick=%b exp leds=80 tick=0", leds_c, tick_c);
        end
        for (int i = 0; i < 3; i++) begin
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            checks++;
            if (leds_c !== exp_s[i] || tick_c !== 1'b1) begin
                failures++;
                $display("FAIL step%0d leds=%h tick=%b exp leds=%h tick=1",
                         i, leds_c, tick_c, exp_s[i]);
            end
            @(negedge clk);
            checks++;
            if (leds_c !== exp_s[i] || tick_c !== 1'b0) begin
                failures++;
                $display("FAIL step%0d_after leds=%h tick=%b exp leds=%h tick=0",
                         i, leds_c, tick_c, exp_s[i]);
            end
        end
        // Steps left the count at zero, so the first enabled advance is LIMIT+1 away.
        en = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick_c && n < 20);
        checks++;
        if (n != 6 || leds_c !== 8'h08) begin
            failures++;
            $display("FAIL resume_from_zero cycles=%0d leds=%h exp cycles=6 leds=08", n, leds_c);
        end
        // Steps while running are ignored.
        step = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (leds_c !== 8'h08) begin
            failures++;
            $display("FAIL step_ignored leds=%h exp 08", leds_c);
        end
        step = 1'b0;
        en = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (leds_c !== 8'h08) begin
            failures++;
            $display("FAIL pause_hold leds=%h exp 08", leds_c);
        end
        en = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick_c && n < 20);
        checks++;
        if (n != 4 || leds_c !== 8'h04) begin
            failures++;
            $display("FAIL resume_partial cycles=%0d leds=%h exp cycles=4 leds=04", n, leds_c);
        end
    endtask

    task automatic test_mode_change_vs_adv();
        int n;
        mode = 2'd0; en = 1'b1; step = 1'b0;
        do_reset();
        repeat (3) @(negedge clk);
        // Count now sits at LIMIT; switch mode on the edge that would advance.
        mode = 2'd1;
        @(negedge clk);
        checks++;
        if (leds_a !== 8'h80 || tick_a !== 1'b0) begin
            failures++;
            $display("FAIL mode_change_edge leds=%h tick=%b exp leds=80 tick=0", leds_a, tick_a);
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick_a && n < 20);
        checks++;
        if (n != 4 || leds_a !== 8'h40) begin
            failures++;
            $display("FAIL after_mode_change cycles=%0d leds=%h exp cycles=4 leds=40", n, leds_a);
        end
    endtask

    task automatic test_async_reset();
        mode = 2'd3; en = 1'b1; step = 1'b0;
        do_reset();
        // Mode-change edge, then fills at cycles 5, 9, 13; cycle 14 is mid-period.
        repeat (14) @(negedge clk);
        checks++;
        if (leds_a !== 8'h07) begin
            failures++;
            $display("FAIL fill_setup leds=%h exp 07", leds_a);
        end
        #2;
        rstn = 1'b0;
        #1;
        rstn = 1'b1;
        #0.5;
        checks++;
        if (leds_a !== 8'h80 || tick_a !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_leds leds=%h tick=%b exp leds=80 tick=0", leds_a, tick_a);
        end
        checks++;
        if (dut_a.mode_q !== 2'd0 || dut_a.u_prescaler.ctr_q !== 32'd0) begin
            failures++;
            $display("FAIL async_reset_state mode=%0d ctr=%0d exp mode=0 ctr=0",
                     dut_a.mode_q, dut_a.u_prescaler.ctr_q);
        end
        // mode_in is still FILL, so the first edge after release is a mode change.
        @(negedge clk);
        checks++;
        if (leds_a !== 8'h00 || tick_a !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_edge leds=%h tick=%b exp leds=00 tick=0", leds_a, tick_a);
        end
    endtask

    initial begin
        test_reset();
        test_rot_l();
        test_bounce();
        test_fill();
        test_step_pause();
        test_mode_change_vs_adv();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
